jtag_tap_ctrl: RTL

IEEE 1149.1-style TAP controller driving the chip's JTAG test-data-register block. It decodes TMS into the 16-state TAP state machine and holds a 4-bit instruction register. It supplies the DR-phase strobes and instruction selects that the test-data-register block consumes. It also owns the IDCODE and BYPASS registers and multiplexes the serial returns from all data registers onto TDO.

---
 rtl/jtag_pkg.sv | 31 +++
 rtl/jtag_tap_fsm.sv | 57 +++++
 rtl/jtag_tap_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state encoding, opcodes and IR constants
package jtag_pkg;
    localparam int IR_LEN = 4;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR         = 4'h0,
        TAP_EXIT1_DR         = 4'h1,
        TAP_SHIFT_DR         = 4'h2,
        TAP_PAUSE_DR         = 4'h3,
        TAP_SELECT_IR        = 4'h4,
        TAP_UPDATE_DR        = 4'h5,
        TAP_CAPTURE_DR       = 4'h6,
        TAP_SELECT_DR        = 4'h7,
        TAP_EXIT2_IR         = 4'h8,
        TAP_EXIT1_IR         = 4'h9,
        TAP_SHIFT_IR         = 4'hA,
        TAP_PAUSE_IR         = 4'hB,
        TAP_RUN_TEST_IDLE    = 4'hC,
        TAP_UPDATE_IR        = 4'hD,
        TAP_CAPTURE_IR       = 4'hE,
        TAP_TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [IR_LEN-1:0] IR_CAPTURE        = 4'b0101;
    localparam logic [IR_LEN-1:0] OP_EXTEST         = 4'h0;
    localparam logic [IR_LEN-1:0] OP_SAMPLE_PRELOAD = 4'h1;
    localparam logic [IR_LEN-1:0] OP_IDCODE         = 4'h2;
    localparam logic [IR_LEN-1:0] OP_MBIST          = 4'h3;
    localparam logic [IR_LEN-1:0] OP_DEBUG          = 4'h8;
    localparam logic [IR_LEN-1:0] OP_BYPASS         = 4'hF;
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP state machine with DR strobe decode
module jtag_tap_fsm (
    input  logic       tck_i,
    input  logic       trst_i,
    input  logic       tms_i,
    output logic [3:0] tap_state_o,
    output logic       test_logic_reset_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       pause_dr_o,
    output logic       update_dr_o
);
    import jtag_pkg::*;

    tap_state_t r_state;
    tap_state_t w_next;

    // state register, async reset forces TEST_LOGIC_RESET
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) r_state <= TAP_TEST_LOGIC_RESET;
        else        r_state <= w_next;
    end

    // standard TMS-driven transitions
    always_comb begin
        w_next = TAP_TEST_LOGIC_RESET;
        case (r_state)
            TAP_TEST_LOGIC_RESET: w_next = tms_i ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
            TAP_RUN_TEST_IDLE:    w_next = tms_i ? TAP_SELECT_DR  : TAP_RUN_TEST_IDLE;
            TAP_SELECT_DR:        w_next = tms_i ? TAP_SELECT_IR  : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR:       w_next = tms_i ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
            TAP_SHIFT_DR:         w_next = tms_i ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
            TAP_EXIT1_DR:         w_next = tms_i ? TAP_UPDATE_DR  : TAP_PAUSE_DR;
            TAP_PAUSE_DR:         w_next = tms_i ? TAP_EXIT2_DR   : TAP_PAUSE_DR;
            TAP_EXIT2_DR:         w_next = tms_i ? TAP_UPDATE_DR  : TAP_SHIFT_DR;
            TAP_UPDATE_DR:        w_next = tms_i ? TAP_SELECT_DR  : TAP_RUN_TEST_IDLE;
            TAP_SELECT_IR:        w_next = tms_i ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR:       w_next = tms_i ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
            TAP_SHIFT_IR:         w_next = tms_i ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
            TAP_EXIT1_IR:         w_next = tms_i ? TAP_UPDATE_IR  : TAP_PAUSE_IR;
            TAP_PAUSE_IR:         w_next = tms_i ? TAP_EXIT2_IR   : TAP_PAUSE_IR;
            TAP_EXIT2_IR:         w_next = tms_i ? TAP_UPDATE_IR  : TAP_SHIFT_IR;
            TAP_UPDATE_IR:        w_next = tms_i ? TAP_SELECT_DR  : TAP_RUN_TEST_IDLE;
            default:              w_next = TAP_TEST_LOGIC_RESET;
        endcase
    end

    // strobes are unregistered decodes of the current state
    always_comb begin
        tap_state_o        = r_state;
        test_logic_reset_o = r_state == TAP_TEST_LOGIC_RESET;
        capture_dr_o       = r_state == TAP_CAPTURE_DR;
        shift_dr_o         = r_state == TAP_SHIFT_DR;
        pause_dr_o         = r_state == TAP_PAUSE_DR;
        update_dr_o        = r_state == TAP_UPDATE_DR;
    end
endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: TAP controller with IR, IDCODE, BYPASS and TDO mux
module jtag_tap_ctrl #(
    parameter int          IR_LEN     = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1180_0001
) (
    input  logic       tck_i,
    input  logic       trst_i,
    input  logic       tms_i,
    input  logic       tdi_i,
    input  logic       debug_tdi_i,
    input  logic       bs_chain_tdi_i,
    input  logic       mbist_tdi_i,
    output logic       test_logic_reset_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       pause_dr_o,
    output logic       update_dr_o,
    output logic       extest_select_o,
    output logic       sample_preload_select_o,
    output logic       mbist_select_o,
    output logic       debug_select_o,
    output logic       idcode_select_o,
    output logic       bypass_select_o,
    output logic       tdo_o,
    output logic       tdo_oe_o,
    output logic [3:0] tap_state_o
);
    import jtag_pkg::*;

    logic [3:0]        w_state;
    logic [IR_LEN-1:0] r_ir;
    logic [IR_LEN-1:0] r_ir_shift;
    logic [31:0]       r_idcode;
    logic              r_bypass;
    logic              w_shift_ir;
    logic              w_shift_dr;
    logic              w_capture_dr;
    logic              w_tdo_mux;

    jtag_tap_fsm u_fsm (
        .tck_i              (tck_i),
        .trst_i             (trst_i),
        .tms_i              (tms_i),
        .tap_state_o        (w_state),
        .test_logic_reset_o (test_logic_reset_o),
        .capture_dr_o       (w_capture_dr),
        .shift_dr_o         (w_shift_dr),
        .pause_dr_o         (pause_dr_o),
        .update_dr_o        (update_dr_o)
    );

    assign tap_state_o  = w_state;
    assign capture_dr_o = w_capture_dr;
    assign shift_dr_o   = w_shift_dr;
    assign w_shift_ir   = w_state == TAP_SHIFT_IR;

    // instruction shift register: capture pattern, then shift right from tdi
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i)                         r_ir_shift <= '0;
        else if (w_state == TAP_CAPTURE_IR) r_ir_shift <= IR_CAPTURE;
        else if (w_shift_ir)                r_ir_shift <= {tdi_i, r_ir_shift[IR_LEN-1:1]};
    end

    // active instruction: IDCODE while in reset, loaded on UPDATE_IR exit
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i)                               r_ir <= OP_IDCODE;
        else if (w_state == TAP_TEST_LOGIC_RESET) r_ir <= OP_IDCODE;
        else if (w_state == TAP_UPDATE_IR)        r_ir <= r_ir_shift;
    end

    // one-hot select decode; unknown opcodes fall through to BYPASS
    always_comb begin
        extest_select_o         = r_ir == OP_EXTEST;
        sample_preload_select_o = r_ir == OP_SAMPLE_PRELOAD;
        idcode_select_o         = r_ir == OP_IDCODE;
        mbist_select_o          = r_ir == OP_MBIST;
        debug_select_o          = r_ir == OP_DEBUG;
        bypass_select_o         = ~(extest_select_o | sample_preload_select_o | idcode_select_o
                                    | mbist_select_o | debug_select_o);
    end

    // IDCODE data register: reload on capture, shift LSB-first
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i)                                 r_idcode <= IDCODE_VAL;
        else if (w_capture_dr && idcode_select_o)   r_idcode <= IDCODE_VAL;
        else if (w_shift_dr && idcode_select_o)     r_idcode <= {tdi_i, r_idcode[31:1]};
    end

    // single-bit BYPASS register
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i)                               r_bypass <= 1'b0;
        else if (w_capture_dr && bypass_select_o) r_bypass <= 1'b0;
        else if (w_shift_dr && bypass_select_o)   r_bypass <= tdi_i;
    end

    // serial return selection by state and active instruction
    always_comb begin
        w_tdo_mux = w_shift_ir ? r_ir_shift[0] :
                    !w_shift_dr ? 1'b0 :
                    idcode_select_o ? r_idcode[0] :
                    bypass_select_o ? r_bypass :
                    (extest_select_o | sample_preload_select_o) ? bs_chain_tdi_i :
                    mbist_select_o ? mbist_tdi_i :
                    debug_select_o ? debug_tdi_i : 1'b0;
    end

    // TDO launches on the falling edge so it is stable at the next rising edge
    always_ff @(negedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_o    <= w_tdo_mux;
            tdo_oe_o <= w_shift_ir | w_shift_dr;
        end
    end
endmodule
